swu_read_scheduler: RTL and testbench



---
 rtl/swu_read_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_swu_read_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/swu_read_scheduler.sv
// Read-side scheduler for the sliding-window circular buffer: walks the conv loop nest,
// issues RAM read addresses and returns write credit. Build macro SWU_SCHED_PERF_EN adds stall counters.
//
// state | meaning
// RUN   | walking the loop nest, issuing reads as data arrives
// LAST  | final element issued, waiting for it to be accepted
// DONE  | frame finished, counters clear for the next frame
module swu_read_scheduler #(
  parameter int IFMChannels   = 2,
  parameter int SIMD          = 1,
  parameter int IFMWidth      = 4,
  parameter int IFMHeight     = 4,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int STRIDE        = 1,
  parameter int BUFFER_SIZE   = 24,
  localparam int EFF_CH = IFMChannels / SIMD,
  localparam int OFMW   = (IFMWidth - KERNEL_WIDTH) / STRIDE + 1,
  localparam int OFMH   = (IFMHeight - KERNEL_HEIGHT) / STRIDE + 1,
  localparam int FRAME  = IFMWidth * IFMHeight * EFF_CH,
  localparam int AW     = $clog2(BUFFER_SIZE),
  localparam int CW     = $clog2(FRAME + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  output logic          wr_ready,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_done
`ifdef SWU_SCHED_PERF_EN
  ,
  output logic [31:0]   stall_data_cnt,
  output logic [31:0]   stall_out_cnt
`endif
);

  localparam int CB  = (EFF_CH > 1) ? $clog2(EFF_CH) : 1;
  localparam int KWB = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;
  localparam int KHB = (KERNEL_HEIGHT > 1) ? $clog2(KERNEL_HEIGHT) : 1;
  localparam int OXB = (OFMW > 1) ? $clog2(OFMW) : 1;
  localparam int OYB = (OFMH > 1) ? $clog2(OFMH) : 1;
  localparam int ROW_STEP = IFMWidth * EFF_CH;
  localparam int COL_STEP = STRIDE * EFF_CH;
  localparam int OY_STEP  = STRIDE * IFMWidth * EFF_CH;

  typedef enum logic [1:0] {RUN = 2'd0, LAST = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [CB-1:0]  c_q, c_d;
  logic [KWB-1:0] kw_q, kw_d;
  logic [KHB-1:0] kh_q, kh_d;
  logic [OXB-1:0] ox_q, ox_d;
  logic [OYB-1:0] oy_q, oy_d;
  logic [CW-1:0]  idx_q, idx_d, row_idx_q, row_idx_d, base_q, base_d, oyb_q, oyb_d;
  logic [AW-1:0]  addr_q, addr_d, row_addr_q, row_addr_d, base_addr_q, base_addr_d;
  logic [AW-1:0]  oyb_addr_q, oyb_addr_d;
  logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
  logic           out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic           last_c, last_kw, last_kh, last_ox, last_oy, frame_end, data_avail;

  // Modulo add for buffer addresses; every step constant is smaller than the buffer.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input int k);
    logic [AW:0] s;
    s = {1'b0, a} + (AW+1)'(k);
    if (s >= (AW+1)'(BUFFER_SIZE)) s = s - (AW+1)'(BUFFER_SIZE);
    return s[AW-1:0];
  endfunction

  assign last_c     = (c_q == CB'(EFF_CH - 1));
  assign last_kw    = (kw_q == KWB'(KERNEL_WIDTH - 1));
  assign last_kh    = (kh_q == KHB'(KERNEL_HEIGHT - 1));
  assign last_ox    = (ox_q == OXB'(OFMW - 1));
  assign last_oy    = (oy_q == OYB'(OFMH - 1));
  assign frame_end  = last_c && last_kw && last_kh && last_ox && last_oy;
  assign data_avail = (idx_q < wr_cnt_q);

  assign wr_ready   = (32'(wr_cnt_q - base_q) < BUFFER_SIZE) && (32'(wr_cnt_q) < FRAME);
  assign rd_en      = (state_q == RUN) && data_avail && (!out_valid_q || out_ready);
  assign rd_addr    = addr_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    kw_d         = kw_q;
    kh_d         = kh_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    idx_d        = idx_q;
    row_idx_d    = row_idx_q;
    base_d       = base_q;
    oyb_d        = oyb_q;
    addr_d       = addr_q;
    row_addr_d   = row_addr_q;
    base_addr_d  = base_addr_q;
    oyb_addr_d   = oyb_addr_q;
    wr_cnt_d     = wr_cnt_q;
    frame_done_d = 1'b0;
    out_valid_d  = rd_en ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    if (wr_en && wr_ready) wr_cnt_d = wr_cnt_q + CW'(1);
    case (state_q)
      RUN: begin
        if (rd_en) begin
          if (frame_end) begin
            state_d = LAST;
          end else if (!last_c || !last_kw) begin
            // Next channel or next kernel column: both are the next element in memory.
            c_d    = last_c ? '0 : c_q + CB'(1);
            kw_d   = last_c ? kw_q + KWB'(1) : kw_q;
            idx_d  = idx_q + CW'(1);
            addr_d = wrap_add(addr_q, 1);
          end else if (!last_kh) begin
            c_d        = '0;
            kw_d       = '0;
            kh_d       = kh_q + KHB'(1);
            row_idx_d  = row_idx_q + CW'(ROW_STEP);
            row_addr_d = wrap_add(row_addr_q, ROW_STEP);
            idx_d      = row_idx_d;
            addr_d     = row_addr_d;
          end else begin
            c_d  = '0;
            kw_d = '0;
            kh_d = '0;
            if (!last_ox) begin
              ox_d        = ox_q + OXB'(1);
              base_d      = base_q + CW'(COL_STEP);
              base_addr_d = wrap_add(base_addr_q, COL_STEP);
            end else begin
              ox_d        = '0;
              oy_d        = oy_q + OYB'(1);
              oyb_d       = oyb_q + CW'(OY_STEP);
              oyb_addr_d  = wrap_add(oyb_addr_q, OY_STEP);
              base_d      = oyb_d;
              base_addr_d = oyb_addr_d;
            end
            idx_d      = base_d;
            row_idx_d  = base_d;
            addr_d     = base_addr_d;
            row_addr_d = base_addr_d;
          end
        end
      end
      LAST: begin
        if (out_valid_q && out_ready) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end
      end
      DONE: begin
        state_d     = RUN;
        c_d         = '0;
        kw_d        = '0;
        kh_d        = '0;
        ox_d        = '0;
        oy_d        = '0;
        idx_d       = '0;
        row_idx_d   = '0;
        base_d      = '0;
        oyb_d       = '0;
        addr_d      = '0;
        row_addr_d  = '0;
        base_addr_d = '0;
        oyb_addr_d  = '0;
        wr_cnt_d    = '0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      c_q          <= '0;
      kw_q         <= '0;
      kh_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      idx_q        <= '0;
      row_idx_q    <= '0;
      base_q       <= '0;
      oyb_q        <= '0;
      addr_q       <= '0;
      row_addr_q   <= '0;
      base_addr_q  <= '0;
      oyb_addr_q   <= '0;
      wr_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      kw_q         <= kw_d;
      kh_q         <= kh_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      idx_q        <= idx_d;
      row_idx_q    <= row_idx_d;
      base_q       <= base_d;
      oyb_q        <= oyb_d;
      addr_q       <= addr_d;
      row_addr_q   <= row_addr_d;
      base_addr_q  <= base_addr_d;
      oyb_addr_q   <= oyb_addr_d;
      wr_cnt_q     <= wr_cnt_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SWU_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_data_cnt <= '0;
      stall_out_cnt  <= '0;
    end else begin
      if ((state_q == RUN) && !data_avail && (stall_data_cnt != '1))
        stall_data_cnt <= stall_data_cnt + 32'd1;
      if (out_valid_q && !out_ready && (stall_out_cnt != '1))
        stall_out_cnt <= stall_out_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_swu_read_scheduler.sv
// Self-checking bench for swu_read_scheduler: random writer/consumer traffic against an im2col reference
// model with a behavioural circular-buffer RAM driven by the DUT's read port.
module tb_swu_read_scheduler;
  localparam int BUF = 24, FRAME = 32, NEL = 72, AW = 5;

  logic clk = 1'b0;
  logic rst, wr_en, out_ready;
  logic wr_ready, rd_en, out_valid, frame_done;
  logic [AW-1:0] rd_addr;
`ifdef SWU_SCHED_PERF_EN
  logic [31:0] stall_data_cnt, stall_out_cnt;
`endif

  always #5 clk = ~clk;

  swu_read_scheduler dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ready(wr_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
`ifdef SWU_SCHED_PERF_EN
    , .stall_data_cnt(stall_data_cnt), .stall_out_cnt(stall_out_cnt)
`endif
  );

  int exp_idx[NEL];
  int exp_base[NEL];
  int mem[BUF];
  int ram_q;
  int wcnt, issued, accepted, frame_id, fd_seen, hs_frame, dut_fd_cnt;
  bit ov_m, fd_m;
  int wr_stop, wr_pct, rdy_pct;
  bit log_en;
  int addr_log[$];
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare against the model, advance the model.
  task automatic cycle();
    int b;
    bit rde, hs, wre;
    wr_en = (wcnt < wr_stop) && ($urandom_range(99) < wr_pct);
    out_ready = ($urandom_range(99) < rdy_pct);
    #1;
    b = exp_base[(issued < NEL) ? issued : NEL - 1];
    wre = ((wcnt - b) < BUF) && (wcnt < FRAME);
    rde = 1'b0;
    if (issued < NEL) rde = (exp_idx[issued] < wcnt) && (!ov_m || out_ready);
    check("wr_ready", wr_ready, wre);
    check("out_valid", out_valid, ov_m);
    check("frame_done", frame_done, fd_m);
    check("rd_en", rd_en, rde);
    if (frame_done === 1'b1) dut_fd_cnt++;
    hs = ov_m && out_ready;
    if (hs) begin
      check("data", ram_q, frame_id * 100 + exp_idx[accepted]);
      accepted++;
      hs_frame++;
    end
    if (rde) begin
      check("rd_addr", rd_addr, exp_idx[issued] % BUF);
      if (log_en && addr_log.size() < 8) addr_log.push_back(int'(rd_addr));
      issued++;
    end
    if (rd_en === 1'b1) ram_q = mem[int'(rd_addr) % BUF];
    if (wr_en && wre) begin
      mem[wcnt % BUF] = frame_id * 100 + wcnt;
      wcnt++;
    end
    ov_m = rde ? 1'b1 : (out_ready ? 1'b0 : ov_m);
    if (fd_m) begin
      wcnt = 0;
      issued = 0;
      accepted = 0;
      frame_id++;
      fd_seen++;
    end
    fd_m = hs && (accepted == NEL);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    wcnt = 0;
    issued = 0;
    accepted = 0;
    ov_m = 1'b0;
    fd_m = 1'b0;
    frame_id++;
  endtask

  task automatic run_frame(input string tag, input int budget);
    int start;
    start = fd_seen;
    for (int i = 0; i < budget && fd_seen == start; i++) cycle();
    check({tag, "_complete"}, fd_seen, start + 1);
    check({tag, "_handshakes"}, hs_frame, NEL);
    check({tag, "_done_pulses"}, dut_fd_cnt, 1);
  endtask

  task automatic new_frame();
    hs_frame = 0;
    dut_fd_cnt = 0;
    addr_log.delete();
  endtask

  initial begin
    int n, q0, first;
    int a_exp[8];
    n = 0;
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 2; ox++)
        for (int kh = 0; kh < 3; kh++)
          for (int kw = 0; kw < 3; kw++)
            for (int c = 0; c < 2; c++) begin
              exp_base[n] = (oy * 4 + ox) * 2;
              exp_idx[n]  = exp_base[n] + (kh * 4 + kw) * 2 + c;
              n++;
            end
    for (int i = 0; i < BUF; i++) mem[i] = -1;
    a_exp = '{0, 1, 2, 3, 4, 5, 8, 9};
    ram_q = -1;
    frame_id = 0;
    fd_seen = 0;
    log_en = 1'b0;
    wr_stop = FRAME;
    @(negedge clk);
    do_reset();

    // Frame A: back-to-back writer, always-ready consumer.
    new_frame();
    log_en = 1'b1;
    wr_pct = 100;
    rdy_pct = 100;
    run_frame("a", 400);
    check("a_addr_count", addr_log.size(), 8);
    for (int i = 0; i < 8; i++) check("a_addr_seq", (i < addr_log.size()) ? addr_log[i] : -1, a_exp[i]);
    log_en = 1'b0;

    // Frame B: writer stalls at 10 elements, then a mid-window output hold.
    new_frame();
    wr_stop = 10;
    for (int i = 0; i < 40; i++) cycle();
    check("stall_issued", issued, 8);
    wr_stop = 11;
    for (int i = 0; i < 10 && wcnt < 11; i++) cycle();
    check("stall_wcnt", wcnt, 11);
    cycle();
    check("resume_issued", issued, 9);
    wr_stop = FRAME;
    for (int i = 0; i < 50 && !(issued >= 12 && ov_m); i++) cycle();
    check("hold_setup_ov", out_valid, 1);
    q0 = ram_q;
    rdy_pct = 0;
    for (int i = 0; i < 5; i++) cycle();
    check("hold_out_valid", out_valid, 1);
    check("hold_data", ram_q, q0);
    rdy_pct = 70;
    run_frame("b", 2000);

    // Frame C: consumer blocked so the writer runs into the credit limit.
    new_frame();
    wr_pct = 100;
    rdy_pct = 0;
    for (int i = 0; i < 40; i++) cycle();
    check("credit_wcnt", wcnt, 24);
    check("credit_blocked", wr_ready, 0);
    rdy_pct = 100;
    for (int i = 0; i < 100 && issued < 18; i++) cycle();
    check("credit_window0", issued, 18);
    check("credit_release", wr_ready, 1);
    run_frame("c", 2000);

    // Frame D: reset after 40 accepted elements, then a fresh full frame.
    new_frame();
    wr_pct = 60;
    rdy_pct = 60;
    for (int i = 0; i < 2000 && accepted < 40; i++) cycle();
    check("d_reached_40", accepted, 40);
    do_reset();
    new_frame();
    log_en = 1'b1;
    run_frame("e", 3000);
    check("e_logged", addr_log.size() > 0, 1);
    first = (addr_log.size() > 0) ? addr_log[0] : -1;
    check("e_first_addr", first, 0);
    log_en = 1'b0;

    // Frame F: sparse writer and consumer.
    new_frame();
    wr_pct = 30;
    rdy_pct = 50;
    run_frame("f", 4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
